// File: rtl/text_term_buf_if.sv
// Character-terminal bus: keyboard input handshake, display read port, cursor and busy status.
// Port summary: in_valid/in_ascii/in_ready (char input), rd_row/rd_col/rd_ascii (display read),
//               cur_row/cur_col (cursor position), busy (clear in progress).
interface text_term_buf_if;
    logic       in_valid;
    logic [7:0] in_ascii;
    logic       in_ready;
    logic [4:0] rd_row;
    logic [6:0] rd_col;
    logic [7:0] rd_ascii;
    logic [4:0] cur_row;
    logic [6:0] cur_col;
    logic       busy;

    // Terminal buffer side
    modport slave (
        input  in_valid, in_ascii, rd_row, rd_col,
        output in_ready, rd_ascii, cur_row, cur_col, busy
    );

    // Keyboard / display side
    modport master (
        output in_valid, in_ascii, rd_row, rd_col,
        input  in_ready, rd_ascii, cur_row, cur_col, busy
    );
endinterface

// File: rtl/text_term_buf.sv
// Text terminal character buffer: ROWS x COLS screen kept as a circular buffer of rows, with cursor, backspace and scroll.
// Latency: rd_ascii is registered one cycle after rd_row/rd_col; a character is consumed in the cycle it is accepted.
// Backpressure: in_ready is low during the power-up clear (ROWS*COLS cycles) and after a scroll (COLS cycles); no input buffering.
// Ports: clk, rst (async active-high); bus (text_term_buf_if.slave) carries input handshake, display read port, cursor, busy.
module text_term_buf #(
    parameter int COLS = 70,
    parameter int ROWS = 30
) (
    input  logic             clk,
    input  logic             rst,
    text_term_buf_if.slave   bus
);

    localparam int         CELLS    = ROWS * COLS;
    localparam int         AW       = $clog2(CELLS);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [AW-1:0] CELLS_M1 = AW'(CELLS - 1);
    localparam logic [AW-1:0] COLS_M1  = AW'(COLS - 1);

    typedef enum logic [1:0] {
        INIT_CLR   = 2'd0,
        IDLE       = 2'd1,
        SCROLL_CLR = 2'd2
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_cnt;
    logic [4:0]      r_cur_row;
    logic [6:0]      r_cur_col;
    logic [4:0]      r_top;
    logic            r_in_ready;
    logic            r_busy;
    logic [7:0]      r_rd_ascii;
    logic [7:0]      r_mem [CELLS];

    logic            w_acc;
    logic            w_print;
    logic            w_nl;
    logic            w_bs;
    logic            w_advance;
    logic            w_we;
    logic [AW-1:0]   w_waddr;
    logic [7:0]      w_wdat;
    logic            w_rd_oob;

    // Screen row -> physical row through the rotating top pointer, then linear cell address.
    function automatic logic [AW-1:0] phys_addr(input logic [4:0] row,
                                                input logic [6:0] col,
                                                input logic [4:0] top);
        int p;
        p = int'(row) + int'(top);
        if (p >= ROWS) p = p - ROWS;
        return AW'(p * COLS + int'(col));
    endfunction

    // in_ready is only ever high in IDLE, so acceptance implies IDLE.
    assign w_acc     = bus.in_valid && r_in_ready;
    assign w_print   = (bus.in_ascii >= 8'h20) && (bus.in_ascii <= 8'h7E);
    assign w_nl      = (bus.in_ascii == 8'h0A) || (bus.in_ascii == 8'h0D);
    assign w_bs      = (bus.in_ascii == 8'h08);
    // A printable char in the last column writes first, then wraps like a newline.
    assign w_advance = w_acc && ((w_print && (r_cur_col == LAST_COL)) || w_nl);

    // Single RAM write port shared by the clears and the character path.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdat  = 8'h20;
        case (r_state)
            INIT_CLR: begin
                w_we    = 1'b1;
                w_waddr = r_cnt;
            end
            SCROLL_CLR: begin
                // top has already advanced, so LAST_ROW is the freshly exposed row.
                w_we    = 1'b1;
                w_waddr = phys_addr(LAST_ROW, 7'(r_cnt), r_top);
            end
            IDLE: begin
                if (w_acc) begin
                    if (w_print) begin
                        w_we    = 1'b1;
                        w_waddr = phys_addr(r_cur_row, r_cur_col, r_top);
                        w_wdat  = bus.in_ascii;
                    end else if (w_bs && (r_cur_col != 7'd0)) begin
                        w_we    = 1'b1;
                        w_waddr = phys_addr(r_cur_row, r_cur_col - 7'd1, r_top);
                    end else if (w_bs && (r_cur_row != 5'd0)) begin
                        w_we    = 1'b1;
                        w_waddr = phys_addr(r_cur_row - 5'd1, LAST_COL, r_top);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdat;
    end

    // Non-blocking write above means a same-cycle read sees the old content.
    assign w_rd_oob = (int'(bus.rd_row) >= ROWS) || (int'(bus.rd_col) >= COLS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ascii <= 8'h20;
        end else if (w_rd_oob) begin
            r_rd_ascii <= 8'h20;
        end else begin
            r_rd_ascii <= r_mem[phys_addr(bus.rd_row, bus.rd_col, r_top)];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= INIT_CLR;
            r_cnt      <= '0;
            r_cur_row  <= 5'd0;
            r_cur_col  <= 7'd0;
            r_top      <= 5'd0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
        end else begin
            case (r_state)
                INIT_CLR: begin
                    if (r_cnt == CELLS_M1) begin
                        r_state    <= IDLE;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                SCROLL_CLR: begin
                    if (r_cnt == COLS_M1) begin
                        r_state    <= IDLE;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (w_advance) begin
                        r_cur_col <= 7'd0;
                        if (r_cur_row == LAST_ROW) begin
                            r_top      <= (r_top == LAST_ROW) ? 5'd0 : r_top + 5'd1;
                            r_state    <= SCROLL_CLR;
                            r_cnt      <= '0;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b1;
                        end else begin
                            r_cur_row <= r_cur_row + 5'd1;
                        end
                    end else if (w_acc && w_print) begin
                        r_cur_col <= r_cur_col + 7'd1;
                    end else if (w_acc && w_bs) begin
                        if (r_cur_col != 7'd0) begin
                            r_cur_col <= r_cur_col - 7'd1;
                        end else if (r_cur_row != 5'd0) begin
                            r_cur_row <= r_cur_row - 5'd1;
                            r_cur_col <= LAST_COL;
                        end
                    end
                end
                default: begin
                    r_state    <= INIT_CLR;
                    r_cnt      <= '0;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.busy     = r_busy;
    assign bus.cur_row  = r_cur_row;
    assign bus.cur_col  = r_cur_col;
    assign bus.rd_ascii = r_rd_ascii;

endmodule

// File: tb/tb_text_term_buf.sv
// Bench for text_term_buf: screen-level model (2D array, cursor, scroll by shifting rows) plus literal pins.
// Latency: compare process checks cursor/flags every falling edge; reads sampled 1 time unit after the edge.
// Backpressure: sends wait (bounded) for in_ready before driving in_valid.
module tb_text_term_buf;
    localparam int COLS = 70;
    localparam int ROWS = 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    text_term_buf_if bus();
    text_term_buf #(.COLS(COLS), .ROWS(ROWS)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Screen-level model
    byte unsigned m_scr [ROWS][COLS];
    int mr, mc, mtop, m_busy_cnt;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) m_scr[r][c] = 8'h20;
        mr = 0; mc = 0; mtop = 0; m_busy_cnt = 0;
    endtask

    task automatic m_newline();
        if (mr == ROWS - 1) begin
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++) m_scr[r][c] = m_scr[r+1][c];
            for (int c = 0; c < COLS; c++) m_scr[ROWS-1][c] = 8'h20;
            mc = 0;
            mtop = (mtop + 1) % ROWS;
            m_busy_cnt = COLS;
        end else begin
            mr++; mc = 0;
        end
    endtask

    task automatic m_apply(input logic [7:0] ch);
        if (ch >= 8'h20 && ch <= 8'h7E) begin
            m_scr[mr][mc] = ch;
            if (mc == COLS - 1) m_newline();
            else mc++;
        end else if (ch == 8'h0A || ch == 8'h0D) begin
            m_newline();
        end else if (ch == 8'h08) begin
            if (mc > 0) begin
                mc--; m_scr[mr][mc] = 8'h20;
            end else if (mr > 0) begin
                mr--; mc = COLS - 1; m_scr[mr][mc] = 8'h20;
            end
        end
    endtask

    function automatic int m_rd(input int r, input int c);
        if (r >= ROWS || c >= COLS) return 8'h20;
        return int'(m_scr[r][c]);
    endfunction

    // Per-cycle compare of cursor, flags and top pointer against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("cur_row", int'(bus.cur_row), mr);
                chk("cur_col", int'(bus.cur_col), mc);
                chk("busy", int'(bus.busy), int'(m_busy_cnt > 0));
                chk("in_ready", int'(bus.in_ready), int'(m_busy_cnt == 0));
                chk("top", int'(dut.r_top), mtop);
                if (m_busy_cnt > 0) m_busy_cnt--;
            end
        end
    end

    task automatic send(input logic [7:0] ch);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) chk("send_wait_timeout", 0, 1);
        bus.in_valid = 1'b1;
        bus.in_ascii = ch;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        m_apply(ch);
    endtask

    task automatic rd_at(input int r, input int c, output logic [7:0] v);
        @(negedge clk);
        bus.rd_row = 5'(r);
        bus.rd_col = 7'(c);
        @(posedge clk);
        #1;
        v = bus.rd_ascii;
    endtask

    task automatic sweep(input string name);
        logic [7:0] v;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                rd_at(r, c, v);
                chk(name, int'(v), m_rd(r, c));
            end
    endtask

    // Release reset away from the edge and count rising edges until in_ready.
    task automatic release_and_count(output int n);
        n = 0;
        @(negedge clk);
        rst = 1'b0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.in_ready && n < 5000);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cur_row"}, int'(bus.cur_row), 0);
        chk({tag, "_cur_col"}, int'(bus.cur_col), 0);
        chk({tag, "_rd_ascii"}, int'(bus.rd_ascii), 8'h20);
        chk({tag, "_in_ready"}, int'(bus.in_ready), 0);
        chk({tag, "_busy"}, int'(bus.busy), 1);
        chk({tag, "_top"}, int'(dut.r_top), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] v;
        logic [7:0] ch;

        bus.in_valid = 1'b0;
        bus.in_ascii = 8'h00;
        bus.rd_row   = 5'd0;
        bus.rd_col   = 7'd0;
        m_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");

        // Power-up clear
        release_and_count(n);
        chk("init_cycles", n, 2100);
        sweep("init_blank");
        rd_at(0, 75, v);
        chk("rd_col75", int'(v), 8'h20);
        rd_at(31, 0, v);
        chk("rd_row31", int'(v), 8'h20);
        chk_en = 1'b1;

        // Edge cases at (0,0): backspace, tab, DEL are ignored
        send(8'h08);
        send(8'h09);
        send(8'h7F);
        #1;
        chk("edge_row", int'(bus.cur_row), 0);
        chk("edge_col", int'(bus.cur_col), 0);
        chk("edge_rdy", int'(bus.in_ready), 1);

        // Print and read back
        send(8'h41);
        send(8'h42);
        rd_at(0, 0, v);
        chk("lit_A", int'(v), 8'h41);
        rd_at(0, 1, v);
        chk("lit_B", int'(v), 8'h42);
        chk("ab_cur_col", int'(bus.cur_col), 2);

        // Wrap and backspace across the row boundary
        send(8'h0D);
        for (int i = 0; i < COLS; i++) send(8'h78);
        chk("wrap_row", int'(bus.cur_row), 2);
        chk("wrap_col", int'(bus.cur_col), 0);
        send(8'h08);
        chk("bs_row", int'(bus.cur_row), 1);
        chk("bs_col", int'(bus.cur_col), 69);
        rd_at(1, 69, v);
        chk("bs_cell", int'(v), 8'h20);
        rd_at(1, 68, v);
        chk("bs_prev", int'(v), 8'h78);
        send(8'h0A);
        sweep("after_wrap");

        // Fresh start, then fill all rows and scroll
        chk_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        release_and_count(n);
        chk("init2_cycles", n, 2100);
        m_reset();
        chk_en = 1'b1;
        for (int r = 0; r < ROWS; r++) begin
            ch = 8'(8'h30 + r);
            for (int k = 0; k < 3; k++) send(ch);
            if (r < ROWS - 1) send(8'h0D);
        end
        send(8'h0D);
        n = 0;
        forever begin
            @(negedge clk);
            if (!bus.busy || n >= 200) break;
            n++;
        end
        chk("scroll_busy_cycles", n, 70);
        chk("scroll_top", int'(dut.r_top), 1);
        chk("scroll_cur_row", int'(bus.cur_row), 29);
        chk("scroll_cur_col", int'(bus.cur_col), 0);
        rd_at(0, 0, v);
        chk("scroll_row0", int'(v), 8'h31);
        rd_at(28, 2, v);
        chk("scroll_row28", int'(v), 8'h4D);
        rd_at(29, 0, v);
        chk("scroll_row29", int'(v), 8'h20);
        sweep("after_scroll");

        // Reset during the scroll clear
        send(8'h0D);
        repeat (10) @(negedge clk);
        chk_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("midrst_hold");
        release_and_count(n);
        chk("init3_cycles", n, 2100);
        m_reset();
        chk_en = 1'b1;
        sweep("after_midrst");

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/text_term_buf.md
TEXT_TERM_BUF -- requirements
Module: text_term_buf

Interface
REQ-001 SHALL have parameter COLS, default 70: characters per screen row.
REQ-002 SHALL have parameter ROWS, default 30: character rows per screen.
REQ-003 SHALL have port clk, input, 1: single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous reset, active-high.
REQ-005 SHALL have port in_valid, input, 1: in_ascii holds a character.
REQ-006 SHALL have port in_ascii, input, 8: ASCII code from the keyboard/scancode stage.
REQ-007 SHALL have port in_ready, output, 1: block accepts a character this cycle.
REQ-008 SHALL have port rd_row, input, 5: screen row requested by the display side.
REQ-009 SHALL have port rd_col, input, 7: screen column requested by the display side.
REQ-010 SHALL have port rd_ascii, output, 8: character at (rd_row, rd_col).
REQ-011 SHALL have port cur_row, output, 5: cursor screen row.
REQ-012 SHALL have port cur_col, output, 7: cursor column.
REQ-013 SHALL have port busy, output, 1: a clear operation is in progress.

Function
REQ-014 SHALL hold a ROWS*COLS x 8-bit character RAM organised as a circular buffer of rows, with a top-row pointer top (0..ROWS-1).
REQ-015 SHALL map screen row r to physical row (r+top) mod ROWS on both read and write.
REQ-016 SHALL register rd_ascii one cycle after rd_row/rd_col are presented.
REQ-017 SHALL return 0x20 for rd_row>=ROWS or rd_col>=COLS.
REQ-018 SHALL return the pre-write content to a read of a location written in the same cycle.
REQ-019 SHALL implement states INIT_CLR, IDLE and SCROLL_CLR.
REQ-020 SHALL drive in_ready=1 only in IDLE, and busy=1 exactly when in INIT_CLR or SCROLL_CLR.
REQ-021 SHALL accept a character when in_valid&&in_ready, at most one per cycle, with no input buffering.
REQ-022 SHALL handle printable input (0x20..0x7E) by writing it at the cursor and then advancing cur_col by 1.
REQ-023 SHALL perform a line advance when cur_col was COLS-1 before a printable write.
REQ-024 SHALL perform a line advance for 0x0A or 0x0D.
REQ-025 SHALL implement a line advance as cur_col=0 and cur_row+1; if cur_row==ROWS-1, it SHALL scroll instead.
REQ-026 SHALL scroll by setting top=(top+1) mod ROWS, keeping cur_row=ROWS-1, setting cur_col=0, and entering SCROLL_CLR.
REQ-027 SHALL, in SCROLL_CLR, write 0x20 to the COLS cells of the new bottom screen row, one per cycle, and then return to IDLE (COLS cycles busy).
REQ-028 SHALL handle 0x08 (backspace) at cur_col>0 by decrementing cur_col and writing 0x20 at the new cursor.
REQ-029 SHALL handle 0x08 at cur_col==0 and cur_row>0 by moving to (cur_row-1, COLS-1) and writing 0x20 there.
REQ-030 SHALL treat 0x08 at (0,0) as a no-op.
REQ-031 SHALL consume and ignore all other codes (0x00..0x07, 0x09, 0x0B, 0x0C, 0x0E..0x1F, 0x7F..0xFF) without state change.
REQ-032 SHALL leave the previously visible rows, seen through the new top, unchanged by a scroll.

Reset
REQ-033 SHALL, while rst=1, asynchronously force cur_row=0, cur_col=0, top=0, rd_ascii=0x20, in_ready=0, busy=1 and state INIT_CLR with clear counter 0.
REQ-034 SHALL, after rst deasserts, write 0x20 to all ROWS*COLS cells in INIT_CLR at one per cycle, then enter IDLE.
REQ-035 SHALL treat rst asserted mid-SCROLL_CLR or mid-INIT_CLR as a full restart of REQ-033/034.

Verification
REQ-036 SHALL verify init clear: release rst and count cycles until in_ready=1 -> exactly 2100 busy cycles; every (r,c) then reads 0x20.
REQ-037 SHALL verify print/read: send 'A' (0x41) then 'B' -> rd (0,0)=0x41 and (0,1)=0x42 one cycle after the address; cursor at (0,2).
REQ-038 SHALL verify wrap and backspace: send 70x 'x' -> cursor at (1,0); send 0x08 -> cursor at (0,69) and (0,69) reads 0x20.
REQ-039 SHALL verify scroll: fill rows 0..29 with row-index chars via 0x0D, then one more 0x0D.
REQ-040 SHALL, in the REQ-039 scenario, see top=1, busy for 70 cycles, screen row 0 showing the old row 1, row 29 all 0x20, and cursor at (29,0).
REQ-041 SHALL verify edge cases: 0x08 at (0,0), 0x09 and 0x7F -> no state change and in_ready stays 1; rd_col=75 -> 0x20.
REQ-042 SHALL verify reset mid-scroll: assert rst during SCROLL_CLR -> outputs at reset values immediately, then a 2100-cycle clear.
